dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Shares the two-port data SRAM (one write port, one read port, active-low chip selects) between up to four requesters: the core load/store unit and auxiliary masters such as a program/data loader or debug port. Each requester issues single-word read or write requests over a valid/ready handshake. Write-port and read-port grants are arbitrated independently, round-robin. Read data is routed back to the issuing requester with a fixed latency. The block sits between the core's memory interface and the `dmem` macro.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters, legal 2..4; requester 0 is the core LSU.
- `ADDR_W`, 8: word address width.
- `DATA_W`, 32: data width; byte mask width is `DATA_W/8`.

Ports:
- `clk_i` in 1: sole clock; SRAM clocks are tied to it outside this block.
- `reset_i` in 1: synchronous, active-high reset.
- `req_valid_i` in NUM_REQ: request present, one bit per requester.
- `req_ready_o` out NUM_REQ: request accepted this cycle.
- `req_we_i` in NUM_REQ: 1 = write, 0 = read.
- `req_addr_i` in NUM_REQ×ADDR_W: word address.
- `req_wdata_i` in NUM_REQ×DATA_W: write data.
- `req_wmask_i` in NUM_REQ×DATA_W/8: byte enables; ignored for reads.
- `rsp_valid_o` out NUM_REQ: read data valid for that requester.
- `rsp_rdata_o` out DATA_W: read data, shared bus, qualified by `rsp_valid_o`.
- `dmem_csb_write_o` out 1: write-port chip select, active low.
- `dmem_wmask_o` out DATA_W/8: write byte mask.
- `dmem_waddr_o` out ADDR_W: write address.
- `dmem_din_o` out DATA_W: write data.
- `dmem_csb_read_o` out 1: read-port chip select, active low.
- `dmem_raddr_o` out ADDR_W: read address.
- `dmem_dout_i` in DATA_W: SRAM read data, valid the cycle after read select.

## Operation
- **Request classes.** In each cycle, requesters with `valid && we` compete for the write port, and requesters with `valid && !we` compete for the read port. At most one grant per port per cycle. Each requester has one request per cycle.
- **Write grant.** `req_ready_o[i]` is high and `dmem_csb_write_o` is low. `wmask`, `waddr` and `din` mux from the winner, with no modification. When no write is granted, `dmem_csb_write_o` is 1 and the other write outputs are 0.
- **Read grant.** `req_ready_o[j]` is high, `dmem_csb_read_o` is low and `dmem_raddr_o` is the winner's address. When no read is granted, `dmem_csb_read_o` is 1 and `dmem_raddr_o` is 0.
- **Arbitration.** Each port keeps a round-robin pointer (`NUM_REQ`-bit one-hot). The highest-priority requester is the pointer position; priority descends cyclically from there. After a grant, that port's pointer moves to winner+1 mod `NUM_REQ`. With no grant, the pointer holds.
- **Same-address hazard.** If the read winner's address equals the write winner's address in the same cycle, the read is not granted that cycle. Its `ready` stays 0 and its pointer does not move. The write proceeds. Next cycle, the read returns the new data.
- **Response tracking.** A one-entry register records a granted read's requester ID. In the next cycle, `rsp_valid_o[id]` is 1 and `rsp_rdata_o = dmem_dout_i`. Responses have no backpressure; requesters must accept them. Back-to-back reads give back-to-back responses.
- **Reset.** All state clears. The response register is invalidated, so a read granted in the cycle before reset produces no `rsp_valid_o`.

## Timing
- Grants and SRAM port signals are combinational from the request inputs and the registered pointers. The SRAM samples on the next `clk_i` rising edge.
- Read latency is fixed: request accepted in cycle N, response in cycle N+1. Write takes effect at the end of cycle N.
- Peak throughput is one write plus one read per cycle.
- While `reset_i` is high:
  - `req_ready_o` = 0 and `rsp_valid_o` = 0.
  - Both csb outputs = 1.
  - Address, mask and data outputs = 0.
  - `rsp_rdata_o` = 0.
- Both pointers reset to requester 0.
- `rsp_rdata_o` is 0 in cycles with no `rsp_valid_o`.
- A request held with `valid` and not granted must stay stable until `ready`. The bench checks this; the block does not enforce it.

## Structure
- Package `dmem_port_pkg`:
  - defines `ADDR_W` and `DATA_W` defaults;
  - defines typedef `mem_req_t` (we, addr, wdata, wmask) and typedef `req_id_t` (2 bits).
- Sub-module `rr_arbiter`, instantiated twice (write port, read port):
  - inputs: request vector, advance enable;
  - output: one-hot grant;
  - contains the registered pointer;
  - the read instance's advance is gated by the hazard check.
- Top level contains the port muxes, the hazard compare and the response ID register.

## Test plan
- **Single read:** requester 0 reads addr 0x10 (SRAM holds 0xDEADBEEF) → ready in cycle N; `rsp_valid_o[0]` and `rsp_rdata_o = 0xDEADBEEF` in N+1.
- **Write contention:** requesters 0 and 1 both write every cycle for 4 cycles → grants alternate 0,1,0,1; `dmem_din_o` tracks the winner; the loser's `ready` is 0.
- **Parallel ports:** requester 0 writes 0x20 with mask 0x3, while requester 1 reads 0x30 in the same cycle → both ready; csb_write = 0 and csb_read = 0; response to 1 in N+1.
- **Hazard:** requester 0 writes 0x11223344 to 0x40 while requester 1 reads 0x40 → the read is deferred one cycle; the response is 0x11223344.
- **Reset mid-read:** read granted in cycle N, `reset_i` high in N+1 → no `rsp_valid_o`; all outputs at reset values; pointers at 0 after release.
- **Idle:** no valid inputs → both csb = 1, ready = 0, pointers unchanged.

Source files
------------

// File: rtl/dmem_port_pkg.sv
// Shared types and default widths for the data-memory port arbiter.
package dmem_port_pkg;

  localparam int DMEM_ADDR_W = 8;
  localparam int DMEM_DATA_W = 32;

  typedef logic [1:0] req_id_t;

  typedef struct packed {
    logic                       we;
    logic [DMEM_ADDR_W-1:0]     addr;
    logic [DMEM_DATA_W-1:0]     wdata;
    logic [DMEM_DATA_W/8-1:0]   wmask;
  } mem_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a one-hot priority pointer; the pointer moves to
// winner+1 only when the caller allows the grant to take effect.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [N-1:0] req_i,
  input  logic         adv_i,
  output logic [N-1:0] gnt_o
);

  logic [N-1:0] r_ptr;
  logic         w_found;

  // Scan cyclically starting at the pointer position; first requester wins.
  always_comb begin
    gnt_o   = '0;
    w_found = 1'b0;
    for (int p = 0; p < N; p++) begin
      if (r_ptr[p]) begin
        for (int k = 0; k < N; k++) begin
          if (!w_found && req_i[(p + k) % N]) begin
            gnt_o[(p + k) % N] = 1'b1;
            w_found            = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_ptr <= {{(N-1){1'b0}}, 1'b1};
    end else if (adv_i && w_found) begin
      r_ptr <= {gnt_o[N-2:0], gnt_o[N-1]};
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the dual-port data SRAM between requesters: independent round-robin
// write/read arbitration, same-address read deferral, fixed 1-cycle read return.
module dmem_port_arbiter
  import dmem_port_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = DMEM_ADDR_W,
  parameter int DATA_W  = DMEM_DATA_W
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic [NUM_REQ-1:0]          req_we_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata_i,
  input  logic [NUM_REQ*DATA_W/8-1:0] req_wmask_i,
  output logic [NUM_REQ-1:0]          rsp_valid_o,
  output logic [DATA_W-1:0]           rsp_rdata_o,
  output logic                        dmem_csb_write_o,
  output logic [DATA_W/8-1:0]         dmem_wmask_o,
  output logic [ADDR_W-1:0]           dmem_waddr_o,
  output logic [DATA_W-1:0]           dmem_din_o,
  output logic                        dmem_csb_read_o,
  output logic [ADDR_W-1:0]           dmem_raddr_o,
  input  logic [DATA_W-1:0]           dmem_dout_i
);

  localparam int MASK_W = DATA_W / 8;

  logic [NUM_REQ-1:0] w_wr_req;
  logic [NUM_REQ-1:0] w_rd_req;
  logic [NUM_REQ-1:0] w_wr_gnt;
  logic [NUM_REQ-1:0] w_rd_gnt;
  logic [NUM_REQ-1:0] w_rd_ok;
  logic [ADDR_W-1:0]  w_waddr;
  logic [DATA_W-1:0]  w_din;
  logic [MASK_W-1:0]  w_wmask;
  logic [ADDR_W-1:0]  w_raddr_sel;
  req_id_t            w_rd_id;
  logic               w_hazard;

  logic               r_rsp_valid;
  req_id_t            r_rsp_id;

  // Masking requests during reset forces every grant-derived output idle.
  assign w_wr_req = reset_i ? '0 : (req_valid_i & req_we_i);
  assign w_rd_req = reset_i ? '0 : (req_valid_i & ~req_we_i);

  rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .req_i   (w_wr_req),
    .adv_i   (1'b1),
    .gnt_o   (w_wr_gnt)
  );

  rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .req_i   (w_rd_req),
    .adv_i   (~w_hazard),
    .gnt_o   (w_rd_gnt)
  );

  always_comb begin
    w_waddr     = '0;
    w_din       = '0;
    w_wmask     = '0;
    w_raddr_sel = '0;
    w_rd_id     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_wr_gnt[i]) begin
        w_waddr = req_addr_i[i*ADDR_W +: ADDR_W];
        w_din   = req_wdata_i[i*DATA_W +: DATA_W];
        w_wmask = req_wmask_i[i*MASK_W +: MASK_W];
      end
      if (w_rd_gnt[i]) begin
        w_raddr_sel = req_addr_i[i*ADDR_W +: ADDR_W];
        w_rd_id     = req_id_t'(i);
      end
    end
  end

  // A read colliding with this cycle's write waits one cycle to see new data.
  assign w_hazard = (|w_wr_gnt) && (|w_rd_gnt) && (w_waddr == w_raddr_sel);
  assign w_rd_ok  = w_hazard ? '0 : w_rd_gnt;

  assign req_ready_o      = w_wr_gnt | w_rd_ok;
  assign dmem_csb_write_o = ~(|w_wr_gnt);
  assign dmem_wmask_o     = w_wmask;
  assign dmem_waddr_o     = w_waddr;
  assign dmem_din_o       = w_din;
  assign dmem_csb_read_o  = ~(|w_rd_ok);
  assign dmem_raddr_o     = (|w_rd_ok) ? w_raddr_sel : '0;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
    end else begin
      r_rsp_valid <= |w_rd_ok;
      if (|w_rd_ok) begin
        r_rsp_id <= w_rd_id;
      end
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    rsp_rdata_o = '0;
    if (r_rsp_valid && !reset_i) begin
      rsp_rdata_o = dmem_dout_i;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (r_rsp_id == req_id_t'(i)) begin
          rsp_valid_o[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural SRAM and a
// queue-based scoreboard checking port outputs and read responses.
module tb_dmem_port_arbiter;

  logic        clk;
  logic        reset_i;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_ready_o;
  logic [1:0]  req_we_i;
  logic [15:0] req_addr_i;
  logic [63:0] req_wdata_i;
  logic [7:0]  req_wmask_i;
  logic [1:0]  rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        dmem_csb_write_o;
  logic [3:0]  dmem_wmask_o;
  logic [7:0]  dmem_waddr_o;
  logic [31:0] dmem_din_o;
  logic        dmem_csb_read_o;
  logic [7:0]  dmem_raddr_o;
  logic [31:0] dmem_dout_i;

  // Port snapshot: {ready, csb_w, wmask, waddr, din, csb_r, raddr}
  localparam logic [55:0] IDLE = {2'b00, 1'b1, 4'h0, 8'h00, 32'h0, 1'b1, 8'h00};
  localparam logic [33:0] NONE = 34'h0;

  logic [55:0] port_q[$];
  logic [33:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc_no   = 0;

  dmem_port_arbiter #(.NUM_REQ(2), .ADDR_W(8), .DATA_W(32)) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_we_i         (req_we_i),
    .req_addr_i       (req_addr_i),
    .req_wdata_i      (req_wdata_i),
    .req_wmask_i      (req_wmask_i),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_rdata_o      (rsp_rdata_o),
    .dmem_csb_write_o (dmem_csb_write_o),
    .dmem_wmask_o     (dmem_wmask_o),
    .dmem_waddr_o     (dmem_waddr_o),
    .dmem_din_o       (dmem_din_o),
    .dmem_csb_read_o  (dmem_csb_read_o),
    .dmem_raddr_o     (dmem_raddr_o),
    .dmem_dout_i      (dmem_dout_i)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- SRAM model ----------------
  logic [31:0] mem [256];
  logic [31:0] r_dout;
  logic        mem_init = 1'b0;
  assign dmem_dout_i = r_dout;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int a = 0; a < 256; a++) mem[a] <= 32'h0;
      mem[8'h10] <= 32'hDEADBEEF;
      mem[8'h20] <= 32'hFFFFFFFF;
      mem[8'h30] <= 32'hCAFEF00D;
      r_dout     <= 32'h0;
      mem_init   <= 1'b1;
    end else begin
      if (!dmem_csb_write_o) begin
        for (int b = 0; b < 4; b++)
          if (dmem_wmask_o[b]) mem[dmem_waddr_o][8*b +: 8] <= dmem_din_o[8*b +: 8];
      end
      if (!dmem_csb_read_o) r_dout <= mem[dmem_raddr_o];
    end
  end

  // ---------------- helpers / driver ----------------
  function automatic logic [55:0] pk(input logic [1:0] rdy, input logic cw,
                                     input logic [3:0] m, input logic [7:0] wa,
                                     input logic [31:0] d, input logic cr,
                                     input logic [7:0] ra);
    return {rdy, cw, m, wa, d, cr, ra};
  endfunction

  task automatic cyc(input logic rst, input logic [1:0] v, input logic [1:0] we,
                     input logic [7:0] a0, input logic [7:0] a1,
                     input logic [31:0] d0, input logic [31:0] d1,
                     input logic [3:0] m0, input logic [3:0] m1,
                     input logic [55:0] ep, input logic [33:0] er);
    @(posedge clk);
    #1;
    reset_i     = rst;
    req_valid_i = v;
    req_we_i    = we;
    req_addr_i  = {a1, a0};
    req_wdata_i = {d1, d0};
    req_wmask_i = {m1, m0};
    cyc_no++;
    port_q.push_back(ep);
    if (er[33:32] != 2'b00) exp_q.push_back(er);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [55:0] act;
    logic [55:0] ep;
    logic [33:0] er;
    if (port_q.size() > 0) begin
      ep  = port_q.pop_front();
      act = {req_ready_o, dmem_csb_write_o, dmem_wmask_o, dmem_waddr_o,
             dmem_din_o, dmem_csb_read_o, dmem_raddr_o};
      n_checks++;
      if (act === ep) n_pass++;
      else $display("FAIL port cyc=%0d actual=%h required=%h", cyc_no, act, ep);
    end
    if (rsp_valid_o != 2'b00) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL rsp_unexpected cyc=%0d actual=%h required=none",
                 cyc_no, {rsp_valid_o, rsp_rdata_o});
      end else begin
        er = exp_q.pop_front();
        if ({rsp_valid_o, rsp_rdata_o} === er) n_pass++;
        else $display("FAIL rsp cyc=%0d actual=%h required=%h",
                      cyc_no, {rsp_valid_o, rsp_rdata_o}, er);
      end
    end else begin
      n_checks++;
      if (rsp_rdata_o === 32'h0) n_pass++;
      else $display("FAIL rdata_idle cyc=%0d actual=%h required=0", cyc_no, rsp_rdata_o);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_i     = 1'b1;
    req_valid_i = '0;
    req_we_i    = '0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    req_wmask_i = '0;

    cyc(1, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0, 4'h0, 4'h0, IDLE, NONE);
    cyc(1, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0, 4'h0, 4'h0, IDLE, NONE);

    // single read
    cyc(0, 2'b01, 2'b00, 8'h10, 8'h00, 0, 0, 4'h0, 4'h0,
        pk(2'b01, 1, 4'h0, 8'h00, 32'h0, 0, 8'h10), {2'b01, 32'hDEADBEEF});
    // idle
    cyc(0, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0, 4'h0, 4'h0, IDLE, NONE);

    // write contention, grants alternate 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0)
        cyc(0, 2'b11, 2'b11, 8'h50, 8'h51, 32'hA0A0A0A0, 32'hB1B1B1B1, 4'hF, 4'hF,
            pk(2'b01, 0, 4'hF, 8'h50, 32'hA0A0A0A0, 1, 8'h00), NONE);
      else
        cyc(0, 2'b11, 2'b11, 8'h50, 8'h51, 32'hA0A0A0A0, 32'hB1B1B1B1, 4'hF, 4'hF,
            pk(2'b10, 0, 4'hF, 8'h51, 32'hB1B1B1B1, 1, 8'h00), NONE);
    end

    // parallel ports: req0 writes 0x20 mask 0x3, req1 reads 0x30
    cyc(0, 2'b11, 2'b01, 8'h20, 8'h30, 32'h12345678, 0, 4'h3, 4'h0,
        pk(2'b11, 0, 4'h3, 8'h20, 32'h12345678, 0, 8'h30), {2'b10, 32'hCAFEF00D});

    // hazard: read of 0x40 deferred behind write of 0x40
    cyc(0, 2'b11, 2'b01, 8'h40, 8'h40, 32'h11223344, 0, 4'hF, 4'h0,
        pk(2'b01, 0, 4'hF, 8'h40, 32'h11223344, 1, 8'h00), NONE);
    cyc(0, 2'b10, 2'b00, 8'h00, 8'h40, 0, 0, 4'h0, 4'h0,
        pk(2'b10, 1, 4'h0, 8'h00, 32'h0, 0, 8'h40), {2'b10, 32'h11223344});

    // masked write result
    cyc(0, 2'b01, 2'b00, 8'h20, 8'h00, 0, 0, 4'h0, 4'h0,
        pk(2'b01, 1, 4'h0, 8'h00, 32'h0, 0, 8'h20), {2'b01, 32'hFFFF5678});

    // read contention, pointer sits at 1
    cyc(0, 2'b11, 2'b00, 8'h10, 8'h30, 0, 0, 4'h0, 4'h0,
        pk(2'b10, 1, 4'h0, 8'h00, 32'h0, 0, 8'h30), {2'b10, 32'hCAFEF00D});
    cyc(0, 2'b11, 2'b00, 8'h10, 8'h30, 0, 0, 4'h0, 4'h0,
        pk(2'b01, 1, 4'h0, 8'h00, 32'h0, 0, 8'h10), {2'b01, 32'hDEADBEEF});

    // reset mid-read: granted read must produce no response
    cyc(0, 2'b01, 2'b00, 8'h10, 8'h00, 0, 0, 4'h0, 4'h0,
        pk(2'b01, 1, 4'h0, 8'h00, 32'h0, 0, 8'h10), NONE);
    cyc(1, 2'b11, 2'b01, 8'h60, 8'h61, 32'h01010101, 0, 4'hF, 4'h0, IDLE, NONE);

    // pointers back at requester 0 after release
    cyc(0, 2'b11, 2'b11, 8'h60, 8'h61, 32'h01010101, 32'h02020202, 4'hF, 4'hF,
        pk(2'b01, 0, 4'hF, 8'h60, 32'h01010101, 1, 8'h00), NONE);
    cyc(0, 2'b11, 2'b00, 8'h60, 8'h61, 0, 0, 4'h0, 4'h0,
        pk(2'b01, 1, 4'h0, 8'h00, 32'h0, 0, 8'h60), {2'b01, 32'h01010101});

    cyc(0, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0, 4'h0, 4'h0, IDLE, NONE);
    cyc(0, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0, 4'h0, 4'h0, IDLE, NONE);

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL rsp_missing actual=%0d pending required=0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
